// File: rtl/regfile_ops_pkg.sv
// Shared definitions for the register-file operand sequencer.
// Holds the default datapath geometry, the ALU op-code values and the
// sequencer FSM state encoding.
package regfile_ops_pkg;

   localparam int unsigned DEF_DATA_W  = 64;
   localparam int unsigned DEF_ADDR_W  = 5;
   localparam int unsigned DEF_IMM_W   = 12;
   localparam int unsigned DEF_ZR_ADDR = 31;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_ORR = 4'd3;
   localparam logic [3:0] OP_EOR = 4'd4;
   localparam logic [3:0] OP_LSL = 4'd5;
   localparam logic [3:0] OP_LSR = 4'd6;
   localparam logic [3:0] OP_MOV = 4'd7;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StExec,
      StWrite
   } seq_state_e;

endpackage

// File: rtl/alu64.sv
// Purely combinational ALU used by the sequencer's EXEC stage.
// Ports:
//   op_i      operation code (8..15 are undefined)
//   a_i, b_i  operands
//   y_o       result (zero for undefined codes; caller ignores it then)
//   illegal_o high when op_i is an undefined code
module alu64
   import regfile_ops_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic [3:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] y_o,
   output logic              illegal_o
);

   localparam int unsigned ShW = $clog2(DATA_W);

   logic [ShW-1:0] sh_amt;
   assign sh_amt = b_i[ShW-1:0];

   always_comb begin
      y_o       = '0;
      illegal_o = 1'b0;
      case (op_i)
         OP_ADD:  y_o = a_i + b_i;
         OP_SUB:  y_o = a_i - b_i;
         OP_AND:  y_o = a_i & b_i;
         OP_ORR:  y_o = a_i | b_i;
         OP_EOR:  y_o = a_i ^ b_i;
         OP_LSL:  y_o = a_i << sh_amt;
         OP_LSR:  y_o = a_i >> sh_amt;
         OP_MOV:  y_o = b_i;
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Four-state (IDLE/READ/EXEC/WRITE) operand-fetch, execute and write-back
// controller placed in front of a 32x64 register file.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   instr_valid/instr_ready       instruction handshake (ready only in IDLE)
//   op, rd, rn, rm, imm, use_imm  instruction fields
//   rf_rdAddrA/B, rf_rdDataA/B    register file read ports (combinational data)
//   rf_write, rf_wrAddr, rf_wrData register file write port
//   result, zero                  last computed value and its zero flag
//   done, illegal                 one-cycle pulses in WRITE
module regfile_op_sequencer
   import regfile_ops_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned IMM_W   = DEF_IMM_W,
   parameter int unsigned ZR_ADDR = DEF_ZR_ADDR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        op,
   input  logic [ADDR_W-1:0] rd,
   input  logic [ADDR_W-1:0] rn,
   input  logic [ADDR_W-1:0] rm,
   input  logic [IMM_W-1:0]  imm,
   input  logic              use_imm,
   output logic [ADDR_W-1:0] rf_rdAddrA,
   input  logic [DATA_W-1:0] rf_rdDataA,
   output logic [ADDR_W-1:0] rf_rdAddrB,
   input  logic [DATA_W-1:0] rf_rdDataB,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_wrAddr,
   output logic [DATA_W-1:0] rf_wrData,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              done,
   output logic              illegal
);

   localparam logic [ADDR_W-1:0] ZrAddr = ADDR_W'(ZR_ADDR);

   seq_state_e        state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [IMM_W-1:0]  imm_q, imm_d;
   logic              use_imm_q, use_imm_d;
   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              zero_q, zero_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;
   logic              illegal_q, illegal_d;
   logic              rf_write_q, rf_write_d;
   logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d;
   logic [ADDR_W-1:0] rd_addr_b_q, rd_addr_b_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic [DATA_W-1:0] alu_y;
   logic              alu_illegal;
   logic [DATA_W-1:0] imm_ext;

   assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm_q};

   alu64 #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op_i      (op_q),
      .a_i       (opa_q),
      .b_i       (opb_q),
      .y_o       (alu_y),
      .illegal_o (alu_illegal)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      rd_d        = rd_q;
      imm_d       = imm_q;
      use_imm_d   = use_imm_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      result_d    = result_q;
      zero_d      = zero_q;
      rd_addr_a_d = rd_addr_a_q;
      rd_addr_b_d = rd_addr_b_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      done_d      = 1'b0;
      illegal_d   = 1'b0;
      rf_write_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (instr_valid) begin
               op_d        = op;
               rd_d        = rd;
               imm_d       = imm;
               use_imm_d   = use_imm;
               // Source addresses go straight to the read-port registers so
               // they are stable for the whole READ cycle.
               rd_addr_a_d = rn;
               rd_addr_b_d = rm;
               state_d     = StRead;
            end
         end
         StRead: begin
            opa_d   = rf_rdDataA;
            opb_d   = use_imm_q ? imm_ext : rf_rdDataB;
            state_d = StExec;
         end
         StExec: begin
            // Write-port values are set up here so they appear, registered,
            // for exactly the WRITE cycle.
            done_d    = 1'b1;
            illegal_d = alu_illegal;
            wr_addr_d = rd_q;
            if (alu_illegal) begin
               wr_data_d = result_q;
            end else begin
               result_d   = alu_y;
               zero_d     = (alu_y == '0);
               wr_data_d  = alu_y;
               rf_write_d = (rd_q != ZrAddr);
            end
            state_d = StWrite;
         end
         StWrite: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         op_q        <= '0;
         rd_q        <= '0;
         imm_q       <= '0;
         use_imm_q   <= 1'b0;
         opa_q       <= '0;
         opb_q       <= '0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         illegal_q   <= 1'b0;
         rf_write_q  <= 1'b0;
         rd_addr_a_q <= '0;
         rd_addr_b_q <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         imm_q       <= imm_d;
         use_imm_q   <= use_imm_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         illegal_q   <= illegal_d;
         rf_write_q  <= rf_write_d;
         rd_addr_a_q <= rd_addr_a_d;
         rd_addr_b_q <= rd_addr_b_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign instr_ready = ready_q;
   assign rf_rdAddrA  = rd_addr_a_q;
   assign rf_rdAddrB  = rd_addr_b_q;
   assign rf_write    = rf_write_q;
   assign rf_wrAddr   = wr_addr_q;
   assign rf_wrData   = wr_data_q;
   assign result      = result_q;
   assign zero        = zero_q;
   assign done        = done_q;
   assign illegal     = illegal_q;

endmodule
